// File: rtl/ahb_sram_slave.sv
// AHB slave data-phase engine over a word-organised SRAM with programmable wait states and a
// two-cycle ERROR response. Define AHB_EXCL_EN to add the single-reservation exclusive monitor.
module ahb_sram_slave #(
    parameter int          MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 2
) (
    input  logic        hclk,
    input  logic        hrst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [6:0]  hprot,
    input  logic        hexcl,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic        hexokay
);
    localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'd4;
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        r_state;
    logic [3:0]    r_wcnt;
    logic          r_hreadyout;
    logic [1:0]    r_hresp;
    logic [AW-1:0] r_widx;
    logic [1:0]    r_lane;
    logic [1:0]    r_size;
    logic          r_write;
    logic          r_excl;
    logic [31:0]   r_mem [MEM_DEPTH];

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_misalign;
    logic          w_err;
    logic          w_accept;
    logic          w_done;
    logic          w_can_acc;
    logic          w_we;
    logic [3:0]    w_be;
    logic          w_unused_bus;

    assign w_off      = haddr - BASE_ADDR;
    assign w_idx      = w_off[AW+1:2];
    assign w_in_range = (haddr >= BASE_ADDR) && ({1'b0, w_off} < MEM_BYTES);
    assign w_misalign = ((hsize == 3'b001) && haddr[0]) ||
                        ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
    assign w_err      = !w_in_range || (hsize > 3'b010) || w_misalign;
    assign w_accept   = hsel && hready && htrans[1];
    assign w_done     = (r_state == S_DATA) && (r_wcnt == 4'd0);
    assign w_can_acc  = (r_state == S_IDLE) || (r_state == S_ERR2) || w_done;
    assign w_unused_bus = ^{hburst, hprot, htrans[0]};

    // Little-endian lane enables; only legal sizes ever reach the data phase
    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            2'b00:   w_be = 4'b0001 << r_lane;
            2'b01:   w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            r_state     <= S_IDLE;
            r_wcnt      <= 4'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= RESP_OKAY;
        end else if (w_can_acc) begin
            if (w_accept && w_err) begin
                r_state     <= S_ERR1;
                r_hreadyout <= 1'b0;
                r_hresp     <= RESP_ERR;
            end else if (w_accept) begin
                r_state     <= S_DATA;
                r_wcnt      <= WS;
                r_hreadyout <= (WS == 4'd0);
                r_hresp     <= RESP_OKAY;
            end else begin
                r_state     <= S_IDLE;
                r_hreadyout <= 1'b1;
                r_hresp     <= RESP_OKAY;
            end
        end else if (r_state == S_DATA) begin
            r_wcnt      <= r_wcnt - 4'd1;
            r_hreadyout <= (r_wcnt == 4'd1);
        end else begin
            r_state     <= S_ERR2;
            r_hreadyout <= 1'b1;
            r_hresp     <= RESP_ERR;
        end
    end

    // Address-phase capture; only meaningful while the FSM is in DATA
    always_ff @(posedge hclk) begin
        if (w_can_acc && w_accept) begin
            r_widx  <= w_idx;
            r_lane  <= haddr[1:0];
            r_size  <= hsize[1:0];
            r_write <= hwrite;
            r_excl  <= hexcl;
        end
    end

`ifdef AHB_EXCL_EN
    logic          r_resv_vld;
    logic [AW-1:0] r_resv_idx;
    logic          w_resv_hit;

    assign w_resv_hit = r_resv_vld && (r_resv_idx == r_widx);
    assign w_we       = w_done && r_write && (!r_excl || w_resv_hit);
    assign hexokay    = w_done && r_excl && (!r_write || w_resv_hit);

    // Any completed write that hits the reservation (exclusive or not) consumes it
    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            r_resv_vld <= 1'b0;
            r_resv_idx <= '0;
        end else if (w_done) begin
            if (r_excl && !r_write) begin
                r_resv_vld <= 1'b1;
                r_resv_idx <= r_widx;
            end else if (r_write && w_resv_hit) begin
                r_resv_vld <= 1'b0;
            end
        end
    end
`else
    logic w_unused_excl;

    assign w_unused_excl = r_excl;
    assign w_we          = w_done && r_write;
    assign hexokay       = 1'b0;
`endif

    always_ff @(posedge hclk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[r_widx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hrdata    = (w_done && !r_write) ? r_mem[r_widx] : 32'h0;
    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: two instances (2 and 0 wait states) driven by a pipelined
// AHB master task, checked every cycle against a transaction-level memory/reservation model.
module tb_ahb_sram_slave;
    localparam logic [31:0] MEM_END = 32'h0000_1000;
`ifdef AHB_EXCL_EN
    localparam bit EXCL = 1'b1;
`else
    localparam bit EXCL = 1'b0;
`endif

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          excl;
    } xfer_t;

    typedef struct {
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        exok;
        bit          fin;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hrst = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b000;
    logic [2:0]  hburst = 3'b000;
    logic [6:0]  hprot = 7'h0;
    logic        hexcl = 1'b0;
    logic [31:0] hwdata = 32'h0;
    logic        act = 1'b0;

    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, exok0, exok1;
    logic [1:0]  resp0, resp1;
    logic        hsel0, hsel1, bus_ready, bus_exok;
    logic [1:0]  bus_resp;
    logic [31:0] bus_rdata;

    assign hsel0     = hsel && !act;
    assign hsel1     = hsel && act;
    assign bus_ready = act ? rdy1 : rdy0;
    assign bus_resp  = act ? resp1 : resp0;
    assign bus_rdata = act ? rd1 : rd0;
    assign bus_exok  = act ? exok1 : exok0;

    ahb_sram_slave #(.MEM_DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut0 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hexcl(hexcl),
        .hwdata(hwdata), .hready(bus_ready), .hrdata(rd0), .hreadyout(rdy0),
        .hresp(resp0), .hexokay(exok0)
    );

    ahb_sram_slave #(.MEM_DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut1 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hexcl(hexcl),
        .hwdata(hwdata), .hready(bus_ready), .hrdata(rd1), .hreadyout(rdy1),
        .hresp(resp1), .hexokay(exok1)
    );

    always #5 hclk = ~hclk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          lowcnt = 0;
    logic [31:0] last_rd = 32'h0;
    logic        last_exok = 1'b0;
    bit          cmp_en = 1'b0;

    logic [31:0] mmem [int];
    bit          resv_vld [2];
    int          resv_idx [2];
    exp_t        expq [$];
    xfer_t       seq [$];
    exp_t        ce;

    function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endfunction

    // Transaction-level model: decides the fate of a beat when it is accepted and queues
    // the per-cycle outputs its data phase must show.
    function automatic void model_accept(input xfer_t x);
        int          ws;
        int          idx;
        int          key;
        bit          err;
        bit          doit;
        bit          exok;
        logic [31:0] w;
        logic [31:0] rdata;
        exp_t        e;
        if (!(x.sel && x.trans[1])) return;
        ws  = act ? 0 : 2;
        err = (x.addr >= MEM_END) || (x.size > 3'd2) ||
              (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'b00);
        if (err) begin
            e = '{1'b0, 2'b01, 32'h0, 1'b0, 1'b0};
            expq.push_back(e);
            e = '{1'b1, 2'b01, 32'h0, 1'b0, 1'b0};
            expq.push_back(e);
            return;
        end
        idx   = int'(x.addr >> 2);
        key   = int'(act) * 4096 + idx;
        rdata = 32'h0;
        exok  = 1'b0;
        doit  = x.wr;
        if (EXCL && x.excl) begin
            if (!x.wr) begin
                resv_vld[act] = 1'b1;
                resv_idx[act] = idx;
                exok = 1'b1;
            end else begin
                exok = resv_vld[act] && (resv_idx[act] == idx);
                doit = exok;
            end
        end
        if (doit) begin
            if (resv_vld[act] && resv_idx[act] == idx) resv_vld[act] = 1'b0;
            w = mmem.exists(key) ? mmem[key] : 32'h0;
            for (int k = 0; k < (1 << x.size); k++) begin
                int ln;
                ln = int'(x.addr[1:0]) + k;
                w[8*ln +: 8] = x.wdata[8*ln +: 8];
            end
            mmem[key] = w;
        end
        if (!x.wr) rdata = mmem.exists(key) ? mmem[key] : 32'h0;
        for (int i = 0; i < ws; i++) begin
            e = '{1'b0, 2'b00, 32'h0, 1'b0, 1'b0};
            expq.push_back(e);
        end
        e = '{1'b1, 2'b00, rdata, exok, 1'b1};
        expq.push_back(e);
    endfunction

    always @(negedge hclk) begin
        if (cmp_en) begin
            if (expq.size() > 0) ce = expq.pop_front();
            else ce = '{1'b1, 2'b00, 32'h0, 1'b0, 1'b0};
            chk("hreadyout", 32'(bus_ready), 32'(ce.rdy));
            chk("hresp", 32'(bus_resp), 32'(ce.resp));
            chk("hrdata", bus_rdata, ce.rdata);
            chk("hexokay", 32'(bus_exok), 32'(ce.exok));
            if (!bus_ready) lowcnt++;
            if (ce.fin) begin
                last_rd   = bus_rdata;
                last_exok = bus_exok;
            end
        end
    end

    function automatic xfer_t mk(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] d, input bit ex = 1'b0,
                                 input logic [1:0] tr = 2'b10, input bit sl = 1'b1);
        xfer_t x;
        x = '{sl, tr, a, wr, sz, d, ex};
        return x;
    endfunction

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'b000; hexcl = 1'b0;
    endtask

    // Pipelined master: address phase of the next beat overlaps the data phase of the current
    task automatic run_seq();
        int ai;
        int di;
        int cyc;
        bit rdy;
        ai = 0; di = -1; cyc = 0;
        while ((ai < seq.size() || di >= 0) && cyc < 200) begin
            if (ai < seq.size()) begin
                hsel = seq[ai].sel; htrans = seq[ai].trans; haddr = seq[ai].addr;
                hwrite = seq[ai].wr; hsize = seq[ai].size; hexcl = seq[ai].excl;
            end else begin
                drive_idle();
            end
            hwdata = (di >= 0) ? seq[di].wdata : 32'h0;
            rdy = bus_ready;
            @(posedge hclk); #1;
            cyc++;
            if (rdy) begin
                if (ai < seq.size()) begin
                    model_accept(seq[ai]);
                    di = (seq[ai].sel && seq[ai].trans[1]) ? ai : -1;
                    ai++;
                end else begin
                    di = -1;
                end
            end
        end
        chk("seq_complete", 32'(cyc < 200), 32'd1);
        drive_idle();
        hwdata = 32'h0;
        seq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resv_vld[0] = 1'b0; resv_vld[1] = 1'b0;
        resv_idx[0] = 0;    resv_idx[1] = 0;
        drive_idle();
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_rdy0", 32'(rdy0), 32'd1);
        chk("rst_resp0", 32'(resp0), 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_exok0", 32'(exok0), 32'd0);
        chk("rst_rdy1", 32'(rdy1), 32'd1);
        chk("rst_resp1", 32'(resp1), 32'd0);
        hrst = 1'b1;
        cmp_en = 1'b1;

        // Word write then read with two wait states
        act = 1'b0;
        seq.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF));
        run_seq();
        lowcnt = 0;
        seq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_seq();
        chk("t1_low_cycles", 32'(lowcnt), 32'd2);
        chk("t1_rdata_lit", last_rd, 32'hDEADBEEF);

        // Byte lane write into the top byte
        seq.push_back(mk(1, 32'h13, 3'd0, 32'hA5000000));
        seq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_seq();
        chk("t2_rdata_lit", last_rd, 32'hA5ADBEEF);
        seq.push_back(mk(1, 32'h12, 3'd1, 32'h12340000));
        seq.push_back(mk(1, 32'h10, 3'd0, 32'h00000077));
        seq.push_back(mk(1, 32'h11, 3'd0, 32'h00006600));
        seq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_seq();
        chk("t2_lanes_lit", last_rd, 32'h12346677);

        // Error responses leave memory untouched; a good beat follows from ERR2
        seq.push_back(mk(1, 32'h0, 3'd2, 32'h01234567));
        seq.push_back(mk(0, 32'h2, 3'd2, 32'h0));
        seq.push_back(mk(1, 32'h0, 3'd3, 32'hFFFFFFFF));
        seq.push_back(mk(1, 32'h1, 3'd1, 32'hFFFFFFFF));
        seq.push_back(mk(1, 32'h1000, 3'd2, 32'hFFFFFFFF));
        seq.push_back(mk(0, 32'h0, 3'd2, 32'h0));
        run_seq();
        chk("t3_unchanged_lit", last_rd, 32'h01234567);
        seq.push_back(mk(1, 32'hFFC, 3'd2, 32'h5A5A0FF0));
        seq.push_back(mk(0, 32'hFFC, 3'd2, 32'h0));
        run_seq();
        chk("t3_lastword_lit", last_rd, 32'h5A5A0FF0);

        // Deselected or BUSY/IDLE cycles get zero-wait OKAY and never write
        seq.push_back(mk(1, 32'h10, 3'd2, 32'h0, 1'b0, 2'b10, 1'b0));
        seq.push_back(mk(1, 32'h10, 3'd2, 32'h0, 1'b0, 2'b01, 1'b1));
        seq.push_back(mk(1, 32'h10, 3'd2, 32'h0, 1'b0, 2'b00, 1'b1));
        seq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_seq();
        chk("t3_nosel_lit", last_rd, 32'h12346677);

        // Zero-wait instance: INCR4 writes, pipelined reads, read right after write
        act = 1'b1;
        lowcnt = 0;
        seq.push_back(mk(1, 32'h20, 3'd2, 32'h00000020, 1'b0, 2'b10));
        seq.push_back(mk(1, 32'h24, 3'd2, 32'h11110024, 1'b0, 2'b11));
        seq.push_back(mk(1, 32'h28, 3'd2, 32'h22220028, 1'b0, 2'b11));
        seq.push_back(mk(1, 32'h2C, 3'd2, 32'h3333002C, 1'b0, 2'b11));
        seq.push_back(mk(0, 32'h20, 3'd2, 32'h0, 1'b0, 2'b10));
        seq.push_back(mk(0, 32'h24, 3'd2, 32'h0, 1'b0, 2'b11));
        seq.push_back(mk(0, 32'h28, 3'd2, 32'h0, 1'b0, 2'b11));
        seq.push_back(mk(0, 32'h2C, 3'd2, 32'h0, 1'b0, 2'b11));
        seq.push_back(mk(1, 32'h34, 3'd1, 32'h0000BEAD));
        seq.push_back(mk(0, 32'h34, 3'd1, 32'h0));
        run_seq();
        chk("t4_no_waits", 32'(lowcnt), 32'd0);
        chk("t4_rdata_lit", last_rd & 32'h0000FFFF, 32'h0000BEAD);
        seq.push_back(mk(0, 32'h2C, 3'd2, 32'h0));
        run_seq();
        chk("t4_burst_lit", last_rd, 32'h3333002C);
        seq.push_back(mk(1, 32'h3, 3'd2, 32'h0));
        run_seq();

        // Exclusive sequence on the wait-state instance
        act = 1'b0;
        seq.push_back(mk(1, 32'h40, 3'd2, 32'h11111111));
        seq.push_back(mk(0, 32'h40, 3'd2, 32'h0, 1'b1));
        run_seq();
        chk("t6_rdexok_lit", 32'(last_exok), 32'(EXCL));
        seq.push_back(mk(1, 32'h40, 3'd2, 32'h22222222, 1'b1));
        run_seq();
        chk("t6_wrexok_lit", 32'(last_exok), 32'(EXCL));
        seq.push_back(mk(1, 32'h40, 3'd2, 32'h33333333, 1'b1));
        run_seq();
        chk("t6_rewr_exok_lit", 32'(last_exok), 32'd0);
        seq.push_back(mk(0, 32'h40, 3'd2, 32'h0));
        run_seq();
        chk("t6_data_lit", last_rd, EXCL ? 32'h22222222 : 32'h33333333);
        seq.push_back(mk(0, 32'h44, 3'd2, 32'h0, 1'b1));
        seq.push_back(mk(1, 32'h44, 3'd0, 32'h000000AA));
        seq.push_back(mk(1, 32'h44, 3'd2, 32'h44444444, 1'b1));
        seq.push_back(mk(0, 32'h44, 3'd2, 32'h0));
        run_seq();
        chk("t6_clr_exok_lit", 32'(last_exok), 32'd0);

        // Reset in the middle of a write data phase abandons the beat
        seq.push_back(mk(1, 32'h30, 3'd2, 32'h11112222));
        run_seq();
        cmp_en = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2; hexcl = 1'b0;
        @(posedge hclk); #1;
        drive_idle();
        hwdata = 32'hCAFEF00D;
        chk("t5_waiting", 32'(rdy0), 32'd0);
        #2 hrst = 1'b0;
        #1;
        chk("t5_rst_rdy", 32'(rdy0), 32'd1);
        chk("t5_rst_resp", 32'(resp0), 32'd0);
        chk("t5_rst_rd", rd0, 32'd0);
        @(posedge hclk); #1;
        hrst = 1'b1;
        hwdata = 32'h0;
        resv_vld[0] = 1'b0; resv_vld[1] = 1'b0;
        expq.delete();
        cmp_en = 1'b1;
        seq.push_back(mk(0, 32'h30, 3'd2, 32'h0));
        run_seq();
        chk("t5_mem_lit", last_rd, 32'h11112222);

        repeat (2) @(posedge hclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
